// File: rtl/src_pkg.sv
// Mini-SRC shared definitions: ALU opcodes, IR field positions, GPR count.
package src_pkg;

  localparam int unsigned NREG   = 16;
  localparam int unsigned RA_LSB = 23;
  localparam int unsigned RB_LSB = 19;
  localparam int unsigned RC_LSB = 15;
  localparam int unsigned C_MSB  = 18;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHRA = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_ROL  = 5'b01001;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

endpackage

// File: rtl/src_alu.sv
// Mini-SRC ALU: A=Y, B=bus, 64-bit result for Z.
// IncPC overrides the opcode with B+1.
module src_alu
  import src_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [4:0]  op_i,
  input  logic        inc_i,
  output logic [63:0] res_o
);

  logic [4:0]         sh;
  logic [63:0]        dbl;
  logic [63:0]        ror_v;
  logic [63:0]        rol_v;
  logic [31:0]        sra_v;
  logic signed [63:0] prod;
  logic signed [31:0] quo;
  logic signed [31:0] rem;

  assign sh    = b_i[4:0];
  assign dbl   = {a_i, a_i};
  assign ror_v = dbl >> sh;
  assign rol_v = dbl << sh;
  assign sra_v = $signed(a_i) >>> sh;
  assign prod  = $signed(a_i) * $signed(b_i);

  always_comb begin
    quo = '0;
    rem = '0;
    if (b_i != '0) begin
      quo = $signed(a_i) / $signed(b_i);
      rem = $signed(a_i) % $signed(b_i);
    end
  end

  always_comb begin
    res_o = '0;
    if (inc_i) begin
      res_o[31:0] = b_i + 32'd1;
    end else begin
      case (op_i)
        OP_LD, OP_LDI, OP_ST,
        OP_ADD, OP_ADDI: res_o[31:0] = a_i + b_i;
        OP_SUB:          res_o[31:0] = a_i - b_i;
        OP_AND, OP_ANDI: res_o[31:0] = a_i & b_i;
        OP_OR, OP_ORI:   res_o[31:0] = a_i | b_i;
        OP_SHR:          res_o[31:0] = a_i >> sh;
        OP_SHRA:         res_o[31:0] = sra_v;
        OP_SHL:          res_o[31:0] = a_i << sh;
        OP_ROR:          res_o[31:0] = ror_v[31:0];
        OP_ROL:          res_o[31:0] = rol_v[63:32];
        OP_MUL:          res_o       = prod;
        OP_DIV:          res_o       = {rem, quo};
        OP_NEG:          res_o[31:0] = -b_i;
        OP_NOT:          res_o[31:0] = ~b_i;
        default:         res_o[31:0] = b_i;
      endcase
    end
  end

endmodule

// File: rtl/datapath.sv
// Mini-SRC datapath: registers, bus mux, Ra/Rb/Rc encoder, ALU and RAM.
// Define EXT_MEM_EN to drop the internal RAM and read memory from Mdatain.
module datapath
  import src_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 512,
  parameter string       MEM_INIT  = ""
) (
  input  logic        Clock,
  input  logic        clear,
  input  logic        PCout,
  input  logic        Zlowout,
  input  logic        Zhighout,
  input  logic        MDRout,
  input  logic        R2out,
  input  logic        R3out,
  input  logic        MARin,
  input  logic        Zin,
  input  logic        PCin,
  input  logic        MDRin,
  input  logic        IRin,
  input  logic        Yin,
  input  logic        LOin,
  input  logic        HIin,
  input  logic        IncPC,
  input  logic        Read,
  input  logic [4:0]  opcode,
  input  logic        R1in,
  input  logic        R2in,
  input  logic        R3in,
  input  logic [31:0] Mdatain,
  input  logic        GRA,
  input  logic        GRB,
  input  logic        GRC,
  input  logic        Rin,
  input  logic        Rout,
  input  logic        BAout,
  input  logic        Write,
  input  logic        Cout,
  input  logic        InportOut,
  input  logic [31:0] InportIn,
  input  logic        OutportIn,
  output logic [31:0] OutportOut,
  output logic [31:0] BusMuxOut
);

  localparam int unsigned AW = $clog2(MEM_DEPTH);
  localparam string unused_mem_init = MEM_INIT;

  logic [31:0] r_q [NREG];
  logic [31:0] pc_q, ir_q, mar_q, mdr_q, y_q;
  logic [31:0] hi_q, lo_q, inport_q, outport_q;
  logic [63:0] z_q;

  logic [3:0]      idx;
  logic [NREG-1:0] ren;
  logic [31:0]     c_val;
  logic [31:0]     mem_data;
  logic [31:0]     mdr_d;
  logic [63:0]     alu_res;
  logic            unused_ok;

  assign idx = ({4{GRA}} & ir_q[RA_LSB +: 4])
             | ({4{GRB}} & ir_q[RB_LSB +: 4])
             | ({4{GRC}} & ir_q[RC_LSB +: 4]);

  assign ren = ({NREG{Rin}} & (NREG'(1) << idx))
             | NREG'({R3in, R2in, R1in, 1'b0});

  assign c_val = {{13{ir_q[C_MSB]}}, ir_q[C_MSB:0]};

  always_comb begin
    BusMuxOut = '0;
    if (PCout)          BusMuxOut = pc_q;
    else if (Zhighout)  BusMuxOut = z_q[63:32];
    else if (Zlowout)   BusMuxOut = z_q[31:0];
    else if (MDRout)    BusMuxOut = mdr_q;
    else if (InportOut) BusMuxOut = inport_q;
    else if (Cout)      BusMuxOut = c_val;
    else if (R2out)     BusMuxOut = r_q[2];
    else if (R3out)     BusMuxOut = r_q[3];
    else if (Rout || BAout) begin
      // R0 reads as zero only for base-address use
      if (BAout && idx == 4'd0) BusMuxOut = '0;
      else                      BusMuxOut = r_q[idx];
    end
  end

`ifdef EXT_MEM_EN
  assign mem_data  = Mdatain;
  assign unused_ok = ^{Write, mar_q[31:AW], mar_q[AW-1:0]};
`else
  logic [31:0] ram [MEM_DEPTH];

  assign mem_data  = ram[mar_q[AW-1:0]];
  assign unused_ok = ^{Mdatain, mar_q[31:AW]};

  always_ff @(posedge Clock) begin
    if (Write) ram[mar_q[AW-1:0]] <= mdr_q;
  end
`endif

  assign mdr_d = Read ? mem_data : BusMuxOut;

  src_alu u_alu (
    .a_i   (y_q),
    .b_i   (BusMuxOut),
    .op_i  (opcode),
    .inc_i (IncPC),
    .res_o (alu_res)
  );

  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      for (int i = 0; i < NREG; i++) r_q[i] <= '0;
      pc_q      <= '0;
      ir_q      <= '0;
      mar_q     <= '0;
      mdr_q     <= '0;
      y_q       <= '0;
      z_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      inport_q  <= '0;
      outport_q <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (ren[i]) r_q[i] <= BusMuxOut;
      end
      if (PCin)      pc_q      <= BusMuxOut;
      if (IRin)      ir_q      <= BusMuxOut;
      if (MARin)     mar_q     <= BusMuxOut;
      if (MDRin)     mdr_q     <= mdr_d;
      if (Yin)       y_q       <= BusMuxOut;
      if (Zin)       z_q       <= alu_res;
      if (HIin)      hi_q      <= BusMuxOut;
      if (LOin)      lo_q      <= BusMuxOut;
      if (OutportIn) outport_q <= BusMuxOut;
      inport_q <= InportIn;
    end
  end

  assign OutportOut = outport_q;

endmodule

// File: tb/tb_datapath.sv
// Scoreboard bench for the Mini-SRC datapath.
module tb_datapath;

  logic        Clock = 1'b0;
  logic        clear;
  logic        PCout, Zlowout, Zhighout, MDRout, R2out, R3out;
  logic        MARin, Zin, PCin, MDRin, IRin, Yin, LOin, HIin;
  logic        IncPC, Read;
  logic [4:0]  opcode;
  logic        R1in, R2in, R3in;
  logic [31:0] Mdatain;
  logic        GRA, GRB, GRC, Rin, Rout, BAout, Write, Cout;
  logic        InportOut;
  logic [31:0] InportIn;
  logic        OutportIn;
  logic [31:0] OutportOut;
  logic [31:0] BusMuxOut;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q [$];
  string       tag_q [$];

  always #5 Clock = ~Clock;

  datapath dut (
    .Clock(Clock), .clear(clear),
    .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout),
    .MDRout(MDRout), .R2out(R2out), .R3out(R3out),
    .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin),
    .IRin(IRin), .Yin(Yin), .LOin(LOin), .HIin(HIin),
    .IncPC(IncPC), .Read(Read), .opcode(opcode),
    .R1in(R1in), .R2in(R2in), .R3in(R3in), .Mdatain(Mdatain),
    .GRA(GRA), .GRB(GRB), .GRC(GRC), .Rin(Rin), .Rout(Rout),
    .BAout(BAout), .Write(Write), .Cout(Cout),
    .InportOut(InportOut), .InportIn(InportIn),
    .OutportIn(OutportIn), .OutportOut(OutportOut),
    .BusMuxOut(BusMuxOut)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic pop(input logic [31:0] got);
    if (exp_q.size() == 0) begin
      chk("sb_underflow", 32'(exp_q.size()), 32'd1);
    end else begin
      chk(tag_q.pop_front(), got, exp_q.pop_front());
    end
  endtask

  task automatic idle();
    {PCout, Zlowout, Zhighout, MDRout, R2out, R3out} = '0;
    {MARin, Zin, PCin, MDRin, IRin, Yin, LOin, HIin} = '0;
    {IncPC, Read, R1in, R2in, R3in} = '0;
    {GRA, GRB, GRC, Rin, Rout, BAout, Write, Cout} = '0;
    {InportOut, OutportIn} = '0;
    opcode = '0;
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic go();
    tick();
    idle();
  endtask

  // put a value into the inport register and drive it onto the bus
  task automatic ld(input logic [31:0] v);
    InportIn = v;
    tick();
    InportOut = 1'b1;
  endtask

  task automatic zop(input logic [31:0] y, input logic [31:0] b,
                     input logic [4:0] op);
    ld(y); Yin = 1'b1; go();
    ld(b); opcode = op; Zin = 1'b1; go();
  endtask

  task automatic zlo(input string tag, input logic [31:0] v);
    push(tag, v);
    Zlowout = 1'b1; #1 pop(BusMuxOut); idle();
  endtask

  task automatic zhi(input string tag, input logic [31:0] v);
    push(tag, v);
    Zhighout = 1'b1; #1 pop(BusMuxOut); idle();
  endtask

  initial begin
    idle();
    clear = 1'b0;
    InportIn = '0;
    Mdatain = '0;
    repeat (2) tick();
    clear = 1'b1;
    tick();

    ld(32'hDEAD_BEEF);
    PCin = 1; Yin = 1; MARin = 1; MDRin = 1; IRin = 1;
    OutportIn = 1; HIin = 1; LOin = 1; R2in = 1; Zin = 1;
    go();
    #2 clear = 1'b0;
    push("rst_pc", '0);  push("rst_ir", '0);  push("rst_mar", '0);
    push("rst_mdr", '0); push("rst_y", '0);   push("rst_hi", '0);
    push("rst_r2", '0);  push("rst_zlo", '0); push("rst_inp", '0);
    push("rst_outp", '0); push("rst_bus", '0);
    #1;
    pop(dut.pc_q);  pop(dut.ir_q);  pop(dut.mar_q);
    pop(dut.mdr_q); pop(dut.y_q);   pop(dut.hi_q);
    pop(dut.r_q[2]); pop(dut.z_q[31:0]); pop(dut.inport_q);
    pop(OutportOut); pop(BusMuxOut);
    clear = 1'b1;
    tick();

    ld(32'h12); MARin = 1; go();
    ld(32'h0100_0095); MDRin = 1; go();
    Write = 1; go();
    ld(32'h0); MDRin = 1; go();
    Read = 1; MDRin = 1; push("mdr_read", 32'h0100_0095); go();
    pop(dut.mdr_q);
    MDRout = 1; IRin = 1; push("mdr_bus", 32'h0100_0095);
    #1 pop(BusMuxOut); go();
    push("mar", 32'h12); push("ir", 32'h0100_0095);
    pop(dut.mar_q); pop(dut.ir_q);

    ld(32'h0000_0212); MARin = 1; go();
    ld(32'h0); MDRin = 1; go();
    Read = 1; MDRin = 1; push("mar_wrap", 32'h0100_0095); go();
    pop(dut.mdr_q);
    ld(32'h5A5A); MDRin = 1; go();
    ld(32'h77); MDRin = 1; Write = 1; push("mdr_wr_new", 32'h77); go();
    pop(dut.mdr_q);
    Read = 1; MDRin = 1; push("wr_old_mdr", 32'h5A5A); go();
    pop(dut.mdr_q);

    ld(32'h0100_0095); IRin = 1; go();
    ld(32'h5); MDRin = 1; go();
    MDRout = 1; GRA = 1; Rin = 1; go();
    R2out = 1; push("r2_gra", 32'h5); #1 pop(BusMuxOut); idle();
    Cout = 1; push("c_pos", 32'h95); #1 pop(BusMuxOut); idle();
    ld(32'h0004_1234); IRin = 1; go();
    Cout = 1; push("c_neg", 32'hFFFC_1234); #1 pop(BusMuxOut); idle();

    ld(32'h0); IRin = 1; go();
    ld(32'hAAAA); GRA = 1; Rin = 1; go();
    GRB = 1; BAout = 1; push("ba_r0", 32'h0); #1 pop(BusMuxOut); idle();
    GRB = 1; Rout = 1; push("rout_r0", 32'hAAAA);
    #1 pop(BusMuxOut); idle();
    ld(32'h0100_0000); IRin = 1; go();
    GRA = 1; BAout = 1; push("ba_r2", 32'h5); #1 pop(BusMuxOut); idle();

    ld(32'h5); Yin = 1; go();
    ld(32'h7); R3in = 1; go();
    R3out = 1; Zin = 1; opcode = 5'b00011; go();
    zlo("add_lo", 32'd12);
    zhi("add_hi", 32'h0);
    R3out = 1; Zin = 1; opcode = 5'b00100; go();
    zlo("sub_lo", 32'hFFFF_FFFE);

    zop(32'hFFFF_FFFE, 32'h3, 5'b01111);
    push("mul_hi", 32'hFFFF_FFFF); push("mul_lo", 32'hFFFF_FFFA);
    Zhighout = 1; HIin = 1; go();
    Zlowout = 1; LOin = 1; go();
    pop(dut.hi_q); pop(dut.lo_q);

    zop(32'hFFFF_FFF9, 32'h2, 5'b10000);
    zlo("div_quo", 32'hFFFF_FFFD);
    zhi("div_rem", 32'hFFFF_FFFF);
    zop(32'h1234, 32'h0, 5'b10000);
    zlo("div0_lo", 32'h0);
    zhi("div0_hi", 32'h0);

    zop(32'h1, 32'h1, 5'b01000);
    zlo("ror1", 32'h8000_0000);
    zop(32'h1, 32'd32, 5'b01000);
    zlo("ror_wrap", 32'h1);
    zop(32'h8000_0001, 32'd4, 5'b01001);
    zlo("rol4", 32'h0000_0018);
    zop(32'h8000_0000, 32'd4, 5'b00110);
    zlo("shra", 32'hF800_0000);
    zop(32'h8000_0000, 32'd4, 5'b00101);
    zlo("shr", 32'h0800_0000);
    zop(32'h0, 32'h0F0F, 5'b10010);
    zlo("not", 32'hFFFF_F0F0);
    zop(32'h0, 32'h3, 5'b10001);
    zlo("neg", 32'hFFFF_FFFD);

    ld(32'h10); PCin = 1; go();
    PCout = 1; IncPC = 1; Zin = 1; opcode = 5'b00100; go();
    Zlowout = 1; PCin = 1; push("pc_inc", 32'h11); go();
    pop(dut.pc_q);
    ld(32'h3333); PCout = 1; push("prio_pc", 32'h11);
    #1 pop(BusMuxOut); idle();
    Zlowout = 1; OutportIn = 1; push("outport", 32'h11); go();
    pop(OutportOut);

    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
